io_input_conditioner: RTL

//  Synchronises and debounces the board switches and push-buttons and drives the
//  14-bit io_input_bus sampled by the data memory's IO read path.
//  Bus layout: [9:0] = switches, [13:10] = buttons, 1 = pressed.

---
 rtl/io_input_conditioner.sv | 100 ++++++++++
 1 files changed

// File: rtl/io_input_conditioner.sv
// Board switch / push-button conditioner: 2-flop synchronisers, a shared debounce
// prescaler, per-bit debounce counters and one-cycle button press pulses.
module io_input_conditioner #(
  parameter int TICK_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [9:0]  sw,
  input  logic [3:0]  key_n,
  output logic [13:0] io_input_bus,
  output logic [3:0]  press_pulse
);

  localparam int NBITS = 14;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT) + 1;
  localparam int DIV_W = $clog2(TICK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [NBITS-1:0] raw;
  logic [NBITS-1:0] s1_q, s2_q;
  logic [NBITS-1:0] db_q, db_d;
  logic [3:0]       btn_last_q;
  logic [3:0]       pulse_q, pulse_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  // Buttons are normalised to 1 = pressed before they enter the synchroniser.
  assign raw = {~key_n, sw};

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      div_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      div_q <= div_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NBITS; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             db_bit_d;

      // Any cycle where the input agrees with the debounced value restarts the window.
      always_comb begin
        cnt_d    = cnt_q;
        db_bit_d = db_q[gi];
        if (s2_q[gi] == db_q[gi]) begin
          cnt_d = '0;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            db_bit_d = s2_q[gi];
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign db_d[gi] = db_bit_d;
    end
  endgenerate

  // The pulse compares the debounced value with its previous cycle, so it
  // trails the bus change by one clock.
  assign pulse_d = db_q[13:10] & ~btn_last_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      db_q       <= '0;
      btn_last_q <= '0;
      pulse_q    <= '0;
    end else begin
      db_q       <= db_d;
      btn_last_q <= db_q[13:10];
      pulse_q    <= pulse_d;
    end
  end

  assign io_input_bus = db_q;
  assign press_pulse  = pulse_q;

endmodule
